// File: rtl/cpu_od_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
// Used by the control FSM and the ALU-op decoder.
package cpu_od_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_BRANCH,
    S_JUMP,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;
  localparam logic [1:0] WD_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // BGE/BGEU test the SLT/SLTU result for zero, i.e. "not less than".
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000, 3'b101, 3'b111: return zero;
      3'b001, 3'b100, 3'b110: return !zero;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU operation decode from the instruction fields.
// Shared between the multi-cycle control FSM and the pipelined core.
module mc_alu_dec
  import cpu_od_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [3:0] op;
  logic       alt;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    op  = ALU_ADD;
    alt = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        // For immediates bit 30 is immediate data except on the shift-right encoding.
        alt = funct7[5] && ((opcode == OP_R) || (funct3 == 3'b101));
        case (funct3)
          3'b000:  op = alt ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = alt ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   op = ALU_SUB;
          2'b10:   op = ALU_SLT;
          2'b11:   op = ALU_SLTU;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_op = ALU_OP_W'(op);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and write enables, with memory-wait timeout and trap.
module mc_ctrl_fsm
  import cpu_od_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                rs2_imm_s,
  output logic                alu_a_s,
  output logic [1:0]          w_data_s,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                trap,
  output logic                bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                bus_err_q, bus_err_d;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                mem_state, tmo_expired, tmo_inc;
  logic                is_r, is_load, is_store, is_lui, is_auipc, is_jalr;

  mc_alu_dec #(.ALU_OP_W(ALU_OP_W)) u_alu_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_alu_op)
  );

  assign is_r     = (opcode == OP_R);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jalr  = (opcode == OP_JALR);

  // Counter saturates at MEM_TIMEOUT; the cycle spent there is the abandon cycle.
  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo_expired = (MEM_TIMEOUT != 0) && mem_state && (tmo_cnt_q == CNT_W'(MEM_TIMEOUT));
  assign tmo_inc     = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && !tmo_expired;

  always_comb begin
    tmo_cnt_d = '0;
    if (tmo_inc) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    bus_err_d = bus_err_q | (tmo_inc && (tmo_cnt_d == CNT_W'(MEM_TIMEOUT)));
  end

  always_comb begin
    state_d   = state_q;
    alu_op    = ALU_OP_W'(ALU_ADD);
    rs2_imm_s = 1'b0;
    alu_a_s   = 1'b0;
    w_data_s  = WD_ALU;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    trap      = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (tmo_expired) begin
          state_d = TRAP_EN ? S_TRAP : S_FETCH;
        end else begin
          mem_read  = 1'b1;
          alu_a_s   = 1'b1;
          rs2_imm_s = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC: state_d = S_EXEC;
          OP_BRANCH:                                       state_d = S_BRANCH;
          OP_JAL, OP_JALR:                                 state_d = S_JUMP;
          default: state_d = TRAP_EN ? S_TRAP : S_FETCH;
        endcase
      end
      S_EXEC: begin
        alu_op    = dec_alu_op;
        rs2_imm_s = !is_r;
        alu_a_s   = is_auipc;
        w_data_s  = is_lui ? WD_IMM : WD_ALU;
        state_d   = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_BRANCH: begin
        alu_op = dec_alu_op;
        if (branch_taken(funct3, alu_zero)) begin
          pc_write = 1'b1;
          pc_src   = PC_IMM;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        w_data_s  = WD_PC4;
        pc_write  = 1'b1;
        pc_src    = is_jalr ? PC_ALU : PC_IMM;
        rs2_imm_s = is_jalr;
        state_d   = S_FETCH;
      end
      S_MEM: begin
        if (tmo_expired) begin
          state_d = TRAP_EN ? S_TRAP : S_FETCH;
        end else begin
          rs2_imm_s = 1'b1;
          if (is_load) begin
            mem_read  = 1'b1;
            w_data_s  = WD_MEM;
            reg_write = mem_ready;
          end else begin
            mem_write = 1'b1;
          end
          if (mem_ready) state_d = S_FETCH;
        end
      end
      S_WB: begin
        alu_op    = dec_alu_op;
        rs2_imm_s = !is_r;
        alu_a_s   = is_auipc;
        w_data_s  = is_lui ? WD_IMM : WD_ALU;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm: each stimulus cycle queues the expected
// output vector, and a negedge monitor pops and compares it.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_op;
  logic       rs2_imm_s, alu_a_s;
  logic [1:0] w_data_s, pc_src;
  logic       reg_write, ir_write, pc_write, mem_read, mem_write, trap, bus_err;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALU_OP_W(4), .MEM_TIMEOUT(15), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .alu_op(alu_op), .rs2_imm_s(rs2_imm_s),
    .alu_a_s(alu_a_s), .w_data_s(w_data_s), .pc_src(pc_src), .reg_write(reg_write),
    .ir_write(ir_write), .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
    .trap(trap), .bus_err(bus_err)
  );

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic [16:0] outs;
  assign outs = {trap, bus_err, mem_read, mem_write, ir_write, pc_write, reg_write,
                 pc_src, w_data_s, alu_a_s, rs2_imm_s, alu_op};

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] FOK, FWAIT, ZERO;

  function automatic logic [16:0] o(input logic [3:0] alu, input logic rs2i, input logic alua,
                                    input logic [1:0] wds, input logic [1:0] pcs,
                                    input logic rw, input logic irw, input logic pcw,
                                    input logic mr, input logic mw, input logic tr, input logic be);
    return {tr, be, mr, mw, irw, pcw, rw, pcs, wds, alua, rs2i, alu};
  endfunction

  task automatic step(input string nm, input logic rst, input logic [6:0] opc,
                      input logic [2:0] f3, input logic [6:0] f7, input logic z,
                      input logic rdy, input logic [16:0] e);
    @(posedge clk); #1;
    rst_n = rst; opcode = opc; funct3 = f3; funct7 = f7; alu_zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    step("reset", 1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, ZERO);
    step("idle", 1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, ZERO);
  endtask

  task automatic alu_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [16:0] ex, input logic [16:0] wb);
    step({nm, " fetch"}, 1'b1, opc, f3, f7, 1'b0, 1'b1, FOK);
    step({nm, " decode"}, 1'b1, opc, f3, f7, 1'b0, 1'b1, ZERO);
    step({nm, " exec"}, 1'b1, opc, f3, f7, 1'b0, 1'b1, ex);
    step({nm, " wb"}, 1'b1, opc, f3, f7, 1'b0, 1'b1, wb);
  endtask

  task automatic short_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                             input logic z, input logic [16:0] e3);
    step({nm, " fetch"}, 1'b1, opc, f3, 7'd0, z, 1'b1, FOK);
    step({nm, " decode"}, 1'b1, opc, f3, 7'd0, z, 1'b1, ZERO);
    step({nm, " resolve"}, 1'b1, opc, f3, 7'd0, z, 1'b1, e3);
  endtask

  // Monitor: compare whenever an expected vector is pending for this cycle.
  initial begin
    logic [16:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (outs !== e) begin
          n_fail++;
          $display("FAIL %s: got %05h expected %05h", nm, outs, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    FOK   = o(4'd0, 1, 1, 2'd0, 2'd0, 0, 1, 1, 1, 0, 0, 0);
    FWAIT = o(4'd0, 1, 1, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0);
    ZERO  = '0;

    do_reset();
    alu_instr("add", R, 3'd0, 7'h00, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                     o(4'd0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("sub", R, 3'd0, 7'h20, o(4'd1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                     o(4'd1, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("sra", R, 3'd5, 7'h20, o(4'd7, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                     o(4'd7, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("srli", I, 3'd5, 7'h00, o(4'd6, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                      o(4'd6, 1, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("srai", I, 3'd5, 7'h20, o(4'd7, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                      o(4'd7, 1, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("addi neg", I, 3'd0, 7'h7f, o(4'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                          o(4'd0, 1, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("andi", I, 3'd7, 7'h00, o(4'd9, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                      o(4'd9, 1, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("lui", LUI, 3'd0, 7'h00, o(4'd0, 1, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                       o(4'd0, 1, 0, 2'd3, 2'd0, 1, 0, 0, 0, 0, 0, 0));
    alu_instr("auipc", AUIPC, 3'd0, 7'h00, o(4'd0, 1, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                           o(4'd0, 1, 1, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));

    step("lw fetch", 1, LD, 3'd2, 7'd0, 0, 1, FOK);
    step("lw decode", 1, LD, 3'd2, 7'd0, 0, 1, ZERO);
    step("lw exec", 1, LD, 3'd2, 7'd0, 0, 1, o(4'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      step("lw mem wait", 1, LD, 3'd2, 7'd0, 0, 0, o(4'd0, 1, 0, 2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 0));
    step("lw mem done", 1, LD, 3'd2, 7'd0, 0, 1, o(4'd0, 1, 0, 2'd1, 2'd0, 1, 0, 0, 1, 0, 0, 0));

    step("sw fetch", 1, ST, 3'd2, 7'd0, 0, 1, FOK);
    step("sw decode", 1, ST, 3'd2, 7'd0, 0, 1, ZERO);
    step("sw exec", 1, ST, 3'd2, 7'd0, 0, 1, o(4'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    step("sw mem", 1, ST, 3'd2, 7'd0, 0, 1, o(4'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0));

    short_instr("beq taken", BR, 3'd0, 1, o(4'd1, 0, 0, 2'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0));
    short_instr("beq not", BR, 3'd0, 0, o(4'd1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    short_instr("bne taken", BR, 3'd1, 0, o(4'd1, 0, 0, 2'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0));
    short_instr("bge not", BR, 3'd5, 0, o(4'd3, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    short_instr("bltu taken", BR, 3'd6, 0, o(4'd4, 0, 0, 2'd0, 2'd1, 0, 0, 1, 0, 0, 0, 0));
    short_instr("jal", JAL, 3'd0, 0, o(4'd0, 0, 0, 2'd2, 2'd1, 1, 0, 1, 0, 0, 0, 0));
    short_instr("jalr", JALR, 3'd0, 0, o(4'd0, 1, 0, 2'd2, 2'd2, 1, 0, 1, 0, 0, 0, 0));

    // Ready arriving on the last allowed wait cycle must not raise bus_err.
    for (int i = 0; i < 14; i++)
      step("fetch wait 14", 1, R, 3'd0, 7'd0, 0, 0, FWAIT);
    alu_instr("late add", R, 3'd0, 7'h00, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                                          o(4'd0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));

    step("illegal fetch", 1, 7'h7f, 3'd0, 7'd0, 0, 1, FOK);
    step("illegal decode", 1, 7'h7f, 3'd0, 7'd0, 0, 1, ZERO);
    step("illegal trap", 1, 7'h7f, 3'd0, 7'd0, 0, 1, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
    step("trap hold", 1, R, 3'd0, 7'd0, 0, 1, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));

    do_reset();
    step("abort fetch", 1, LD, 3'd2, 7'd0, 0, 1, FOK);
    step("abort decode", 1, LD, 3'd2, 7'd0, 0, 1, ZERO);
    step("abort exec", 1, LD, 3'd2, 7'd0, 0, 1, o(4'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
    step("abort mem wait", 1, LD, 3'd2, 7'd0, 0, 0, o(4'd0, 1, 0, 2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 0));
    step("rst mid mem", 0, LD, 3'd2, 7'd0, 0, 1, ZERO);
    step("idle after rst", 1, LD, 3'd2, 7'd0, 0, 1, ZERO);
    step("fetch after rst", 1, LD, 3'd2, 7'd0, 0, 1, FOK);

    do_reset();
    for (int i = 0; i < 15; i++)
      step("tmo wait", 1, R, 3'd0, 7'd0, 0, 0, FWAIT);
    step("tmo bus_err", 1, R, 3'd0, 7'd0, 0, 0, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
    step("tmo trap", 1, R, 3'd0, 7'd0, 0, 0, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1));
    step("tmo trap late ready", 1, R, 3'd0, 7'd0, 0, 1, o(4'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1));
    do_reset();

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
